// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and defaults for the multiplier-sharing controller and its arbiter.
package mult_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_TIMEOUT = 15;

   function automatic int idx_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Bus between the sharing controller (master) and the single shift-add multiplier (slave).
interface mult_share_ctrl_if #(
   parameter int WIDTH = 4
);
   logic                 mul_start;
   logic [WIDTH-1:0]     mul_a;
   logic [WIDTH-1:0]     mul_b;
   logic [2*WIDTH-1:0]   mul_product;
   logic                 mul_valid;
   logic                 mul_flush;

   modport master (
      output mul_start, mul_a, mul_b, mul_flush,
      input  mul_product, mul_valid
   );

   modport slave (
      input  mul_start, mul_a, mul_b, mul_flush,
      output mul_product, mul_valid
   );
endinterface

// File: rtl/mult_share_ctrl_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping upward.
module rr_pick
   import mult_ctrl_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IW      = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic [IW-1:0]      pick_idx,
   output logic               any
);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [IW-1:0] cand_s;

   // Walk the offsets downward so the smallest offset from ptr wins last.
   always_comb begin
      cand_s   = '0;
      pick_idx = '0;
      any      = |req;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand_s   = IW'((int'(ptr) + k) % NUM_REQ);
         pick_idx = req[cand_s] ? cand_s : pick_idx;
      end
      pick = any ? (ONE_HOT0 << pick_idx) : '0;
   end
endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin owner of one shared shift-add multiplier: latches operands, issues start,
// waits for a fresh valid edge (or times out and flushes), and returns the product.
module mult_share_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_REQ-1:0]         resp_valid,
   output logic [2*WIDTH-1:0]         resp_product,
   output logic                       resp_err,
   output logic                       busy,
   mult_share_ctrl_if.master          mul
);
   localparam int IW = idx_width(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   state_t               state_r, state_s;
   logic [IW-1:0]        ptr_r, ptr_s, owner_r, owner_s;
   logic [CW-1:0]        cnt_r, cnt_s;
   logic                 valid_q_r, done_s;
   logic [NUM_REQ-1:0]   grant_r, grant_s, resp_valid_r, resp_valid_s;
   logic [2*WIDTH-1:0]   resp_product_r, resp_product_s;
   logic                 resp_err_r, resp_err_s, busy_r, busy_s;
   logic                 mul_start_r, mul_start_s, mul_flush_r, mul_flush_s;
   logic [WIDTH-1:0]     mul_a_r, mul_a_s, mul_b_r, mul_b_s;
   logic [NUM_REQ-1:0]   pick_s;
   logic [IW-1:0]        pick_idx_s;
   logic                 pick_any_s;

   rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req      (req),
      .ptr      (ptr_r),
      .pick     (pick_s),
      .pick_idx (pick_idx_s),
      .any      (pick_any_s)
   );

   // A valid level left over from an earlier operation must not count as completion.
   assign done_s = mul.mul_valid & ~valid_q_r;

   // Next-state and next-output decode.
   always_comb begin
      state_s        = state_r;
      ptr_s          = ptr_r;
      owner_s        = owner_r;
      cnt_s          = cnt_r;
      grant_s        = '0;
      resp_valid_s   = '0;
      mul_start_s    = 1'b0;
      mul_flush_s    = 1'b0;
      mul_a_s        = mul_a_r;
      mul_b_s        = mul_b_r;
      resp_product_s = resp_product_r;
      resp_err_s     = resp_err_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_any_s) begin
               owner_s     = pick_idx_s;
               grant_s     = pick_s;
               mul_start_s = 1'b1;
               mul_a_s     = req_a[int'(pick_idx_s)*WIDTH +: WIDTH];
               mul_b_s     = req_b[int'(pick_idx_s)*WIDTH +: WIDTH];
               state_s     = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_s   = '0;
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (done_s) begin
               resp_product_s = mul.mul_product;
               resp_err_s     = 1'b0;
               resp_valid_s   = ONE_HOT0 << owner_r;
               state_s        = ST_RESP;
            end else if (cnt_r == CW'(TIMEOUT - 1)) begin
               resp_product_s = '0;
               resp_err_s     = 1'b1;
               mul_flush_s    = 1'b1;
               resp_valid_s   = ONE_HOT0 << owner_r;
               state_s        = ST_RESP;
            end else begin
               cnt_s = cnt_r + CW'(1'b1);
            end
         end
         ST_RESP: begin
            ptr_s   = (owner_r == IW'(NUM_REQ - 1)) ? '0 : owner_r + IW'(1'b1);
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Registered datapath and outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r          <= '0;
         owner_r        <= '0;
         cnt_r          <= '0;
         valid_q_r      <= 1'b0;
         grant_r        <= '0;
         resp_valid_r   <= '0;
         resp_product_r <= '0;
         resp_err_r     <= 1'b0;
         busy_r         <= 1'b0;
         mul_start_r    <= 1'b0;
         mul_flush_r    <= 1'b0;
         mul_a_r        <= '0;
         mul_b_r        <= '0;
      end else begin
         ptr_r          <= ptr_s;
         owner_r        <= owner_s;
         cnt_r          <= cnt_s;
         valid_q_r      <= mul.mul_valid;
         grant_r        <= grant_s;
         resp_valid_r   <= resp_valid_s;
         resp_product_r <= resp_product_s;
         resp_err_r     <= resp_err_s;
         busy_r         <= busy_s;
         mul_start_r    <= mul_start_s;
         mul_flush_r    <= mul_flush_s;
         mul_a_r        <= mul_a_s;
         mul_b_r        <= mul_b_s;
      end
   end

   assign grant         = grant_r;
   assign resp_valid    = resp_valid_r;
   assign resp_product  = resp_product_r;
   assign resp_err      = resp_err_r;
   assign busy          = busy_r;
   assign mul.mul_start = mul_start_r;
   assign mul.mul_flush = mul_flush_r;
   assign mul.mul_a     = mul_a_r;
   assign mul.mul_b     = mul_b_r;
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench: behavioural 4-stage multiplier stand-in plus a round-robin/latency reference.
module tb_mult_share_ctrl;
   import mult_ctrl_pkg::*;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int TO = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req;
   logic [N*W-1:0]   req_a, req_b;
   logic [N-1:0]     grant, resp_valid;
   logic [2*W-1:0]   resp_product;
   logic             resp_err, busy;

   mult_share_ctrl_if #(.WIDTH(W)) mif ();

   mult_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_a        (req_a),
      .req_b        (req_b),
      .grant        (grant),
      .resp_valid   (resp_valid),
      .resp_product (resp_product),
      .resp_err     (resp_err),
      .busy         (busy),
      .mul          (mif.master)
   );

   always #5 clk = ~clk;

   // Multiplier stand-in: one b bit per stage, read live from the bus, valid after edge start+5.
   int             stage;
   logic [2*W-1:0] acc, prod;
   logic           mvalid, dead, stale;

   always @(posedge clk) begin
      if (reset || mif.mul_flush) begin
         stage <= 0; acc <= '0; prod <= '0; mvalid <= 1'b0;
      end else if (mif.mul_start) begin
         stage <= 1; acc <= '0; mvalid <= 1'b0;
      end else if (stage >= 1 && stage <= 4) begin
         if (mif.mul_b[stage-1]) acc <= acc + ({4'b0000, mif.mul_a} << (stage - 1));
         stage <= stage + 1;
      end else if (stage == 5) begin
         prod <= acc; mvalid <= ~dead; stage <= 0;
      end
   end

   assign mif.mul_valid   = mvalid | stale;
   assign mif.mul_product = prod;

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;

   function automatic int model_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic wait_grant(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (grant === '0 && n < 40);
   endtask

   task automatic wait_resp(input int bound, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (resp_valid === '0 && n < bound);
   endtask

   task automatic apply_reset;
      reset = 1'b1; req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0; model_ptr = 0;
   endtask

   task automatic test_reset;
      reset = 1'b1; req = '0; req_a = '0; req_b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({grant, resp_valid, resp_product, resp_err, busy, mif.mul_start, mif.mul_a, mif.mul_b, mif.mul_flush} !== '0) begin
         errors++; $display("FAIL reset_outputs grant=%b resp_valid=%b prod=%0d busy=%b start=%b flush=%b want all 0",
                            grant, resp_valid, resp_product, busy, mif.mul_start, mif.mul_flush);
      end
      reset = 1'b0; model_ptr = 0;
   endtask

   task automatic test_single;
      int n, m;
      req_a = '0; req_b = '0;
      req_a[11:8] = 4'd13; req_b[11:8] = 4'd11; req = 4'b0100;
      wait_grant(n);
      checks++;
      if (grant !== 4'b0100 || n != 1) begin
         errors++; $display("FAIL single_grant grant=%b cycle=%0d want 0100 cycle 1", grant, n);
      end
      checks++;
      if (mif.mul_start !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL single_start start=%b busy=%b want 1 1", mif.mul_start, busy);
      end
      req = '0;
      wait_resp(20, m);
      checks++;
      if (resp_valid !== 4'b0100 || m != 7) begin
         errors++; $display("FAIL single_resp resp_valid=%b cycle=%0d want 0100 cycle 8", resp_valid, m + 1);
      end
      checks++;
      if (resp_product !== 8'd143 || resp_err !== 1'b0) begin
         errors++; $display("FAIL single_product got %0d err=%b want 143 err 0", resp_product, resp_err);
      end
      model_ptr = 3;
   endtask

   task automatic test_round_robin;
      int ea[N], eb[N];
      int n, m, exp_i, prev_m;
      logic [2*W-1:0] exp_p;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         ea[i] = i + 1; eb[i] = 15;
         req_a[i*W +: W] = W'(ea[i]); req_b[i*W +: W] = W'(eb[i]);
      end
      req = 4'b1111;
      prev_m = 0;
      for (int k = 0; k < 8; k++) begin
         wait_grant(n);
         exp_i = model_pick(4'b1111, model_ptr);
         checks++;
         if (grant !== (4'b0001 << exp_i)) begin
            errors++; $display("FAIL rr_order op=%0d grant=%b want requester %0d", k, grant, exp_i);
         end
         if (k > 0) begin
            checks++;
            if (prev_m + n != 9) begin
               errors++; $display("FAIL rr_spacing op=%0d spacing=%0d want 9", k, prev_m + n);
            end
         end
         exp_p = 8'(ea[exp_i] * eb[exp_i]);
         ea[exp_i] = int'($urandom_range(0, 15)); eb[exp_i] = int'($urandom_range(0, 15));
         req_a[exp_i*W +: W] = W'(ea[exp_i]); req_b[exp_i*W +: W] = W'(eb[exp_i]);
         wait_resp(20, m);
         prev_m = m;
         checks++;
         if (resp_valid !== (4'b0001 << exp_i) || resp_product !== exp_p || resp_err !== 1'b0) begin
            errors++; $display("FAIL rr_result op=%0d resp_valid=%b prod=%0d err=%b want owner %0d prod %0d",
                               k, resp_valid, resp_product, resp_err, exp_i, exp_p);
         end
         model_ptr = (exp_i + 1) % N;
      end
      req = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random_ops;
      int n, m, exp_i;
      logic [N-1:0] r;
      logic [W-1:0] a, b;
      for (int k = 0; k < 6; k++) begin
         r = N'($urandom_range(1, 15));
         req_a = N*W'($urandom); req_b = N*W'($urandom);
         exp_i = model_pick(r, model_ptr);
         a = req_a[exp_i*W +: W]; b = req_b[exp_i*W +: W];
         req = r;
         wait_grant(n);
         checks++;
         if (grant !== (4'b0001 << exp_i) || mif.mul_a !== a || mif.mul_b !== b) begin
            errors++; $display("FAIL rand_grant req=%b grant=%b a=%0d b=%0d want requester %0d a=%0d b=%0d",
                               r, grant, mif.mul_a, mif.mul_b, exp_i, a, b);
         end
         req = '0;
         wait_resp(20, m);
         checks++;
         if (resp_valid !== (4'b0001 << exp_i) || resp_product !== 8'(a * b) || m != 7) begin
            errors++; $display("FAIL rand_result resp_valid=%b prod=%0d cycles=%0d want owner %0d prod %0d cycles 7",
                               resp_valid, resp_product, m, exp_i, 8'(a * b));
         end
         model_ptr = (exp_i + 1) % N;
         @(negedge clk);
      end
   endtask

   task automatic test_operand_hold;
      int n, m;
      logic [W-1:0] a, b;
      a = W'($urandom_range(1, 15)); b = W'($urandom_range(1, 15));
      req_a[3:0] = a; req_b[3:0] = b; req = 4'b0001;
      wait_grant(n);
      req = '0;
      repeat (2) @(negedge clk);
      req_a[3:0] = ~a; req_b[3:0] = ~b;
      @(negedge clk);
      checks++;
      if (mif.mul_a !== a || mif.mul_b !== b) begin
         errors++; $display("FAIL hold_operands mul_a=%0d mul_b=%0d want %0d %0d", mif.mul_a, mif.mul_b, a, b);
      end
      wait_resp(20, m);
      checks++;
      if (resp_valid !== 4'b0001 || resp_product !== 8'(a * b)) begin
         errors++; $display("FAIL hold_product resp_valid=%b prod=%0d want 0001 prod %0d", resp_valid, resp_product, 8'(a * b));
      end
      model_ptr = 1;
      @(negedge clk);
   endtask

   task automatic test_stale_valid;
      int n, m, q;
      bit early;
      logic [W-1:0] a, b;
      stale = 1'b1;
      repeat (2) @(negedge clk);
      q = int'($urandom_range(0, N - 1));
      a = W'($urandom); b = W'($urandom);
      req_a[q*W +: W] = a; req_b[q*W +: W] = b; req = 4'b0001 << q;
      wait_grant(n);
      req = '0;
      early = 1'b0;
      repeat (2) begin @(negedge clk); if (resp_valid !== '0) early = 1'b1; end
      stale = 1'b0;
      checks++;
      if (early) begin
         errors++; $display("FAIL stale_early resp_valid seen while mul_valid was stale-high, want none");
      end
      wait_resp(20, m);
      checks++;
      if (resp_valid !== (4'b0001 << q) || resp_product !== 8'(a * b) || m + 2 != 7) begin
         errors++; $display("FAIL stale_result resp_valid=%b prod=%0d cycles=%0d want owner %0d prod %0d cycles 7",
                            resp_valid, resp_product, m + 2, q, 8'(a * b));
      end
      model_ptr = (q + 1) % N;
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int n, m, q, exp_i;
      logic [W-1:0] a, b;
      dead = 1'b1;
      q = int'($urandom_range(0, N - 1));
      req_a = N*W'($urandom); req_b = N*W'($urandom); req = 4'b0001 << q;
      wait_grant(n);
      req = '0;
      wait_resp(40, m);
      checks++;
      if (resp_valid !== (4'b0001 << q) || m != 16) begin
         errors++; $display("FAIL timeout_resp resp_valid=%b cycles=%0d want owner %0d cycles 16", resp_valid, m, q);
      end
      checks++;
      if (resp_err !== 1'b1 || resp_product !== '0 || mif.mul_flush !== 1'b1) begin
         errors++; $display("FAIL timeout_flags err=%b prod=%0d flush=%b want 1 0 1", resp_err, resp_product, mif.mul_flush);
      end
      @(negedge clk);
      checks++;
      if (mif.mul_flush !== 1'b0 || resp_valid !== '0) begin
         errors++; $display("FAIL timeout_pulse flush=%b resp_valid=%b want 0 0", mif.mul_flush, resp_valid);
      end
      model_ptr = (q + 1) % N;
      dead = 1'b0;
      exp_i = model_pick(4'b1111, model_ptr);
      a = W'($urandom); b = W'($urandom);
      req_a[exp_i*W +: W] = a; req_b[exp_i*W +: W] = b; req = 4'b1111;
      wait_grant(n);
      req = '0;
      wait_resp(20, m);
      checks++;
      if (resp_valid !== (4'b0001 << exp_i) || resp_product !== 8'(a * b) || resp_err !== 1'b0) begin
         errors++; $display("FAIL after_timeout resp_valid=%b prod=%0d err=%b want owner %0d prod %0d err 0",
                            resp_valid, resp_product, resp_err, exp_i, 8'(a * b));
      end
      model_ptr = (exp_i + 1) % N;
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int n, m, seen;
      logic [W-1:0] a, b;
      req_a = N*W'($urandom); req_b = N*W'($urandom);
      req = 4'b0010;
      wait_grant(n);
      req = '0;
      wait_resp(20, m);
      @(negedge clk);
      req = 4'b0100;
      wait_grant(n);
      req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({grant, resp_valid, resp_product, resp_err, busy, mif.mul_start, mif.mul_a, mif.mul_b, mif.mul_flush} !== '0) begin
         errors++; $display("FAIL midreset_outputs grant=%b resp_valid=%b prod=%0d busy=%b want all 0",
                            grant, resp_valid, resp_product, busy);
      end
      reset = 1'b0; model_ptr = 0;
      seen = 0;
      repeat (15) begin @(negedge clk); if (resp_valid !== '0) seen++; end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL midreset_noresp resp_valid seen %0d times want 0", seen);
      end
      a = W'($urandom); b = W'($urandom);
      req_a[7:4] = a; req_b[7:4] = b; req = 4'b1010;
      wait_grant(n);
      checks++;
      if (grant !== (4'b0001 << model_pick(4'b1010, model_ptr))) begin
         errors++; $display("FAIL midreset_ptr grant=%b want 0010", grant);
      end
      req = '0;
      wait_resp(20, m);
      checks++;
      if (resp_valid !== 4'b0010 || resp_product !== 8'(a * b)) begin
         errors++; $display("FAIL midreset_result resp_valid=%b prod=%0d want 0010 prod %0d", resp_valid, resp_product, 8'(a * b));
      end
   endtask

   initial begin
      dead = 1'b0; stale = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_random_ops();
      test_operand_hold();
      test_stale_valid();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
